// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared multicycle MIPS datapath.
// Memory states stretch by MEM_WAIT cycles; unsupported opcodes park in ILLEGAL.
module multicycle_controller #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [3:0] state,
    output logic       pc_en,
    output logic       pc_write,
    output logic       branch,
    output logic       pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ILLEGAL  = 4'd9
    } state_t;

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [3:0] WAIT   = 4'(MEM_WAIT);

    state_t     cur;
    logic [3:0] cnt;
    logic       last;

    assign last  = (cnt == WAIT);
    assign state = cur;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cur <= S_FETCH;
            cnt <= '0;
        end else begin
            case (cur)
                S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                    if (last) begin
                        cnt <= '0;
                        case (cur)
                            S_FETCH:   cur <= S_DECODE;
                            S_MEMREAD: cur <= S_MEMWB;
                            default:   cur <= S_FETCH;
                        endcase
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_DECODE: begin
                    cnt <= '0;
                    case (opcode)
                        OP_LW, OP_SW: cur <= S_MEMADR;
                        OP_R:         cur <= S_EXECUTE;
                        OP_BEQ:       cur <= S_BRANCH;
                        default:      cur <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR: begin
                    cnt <= '0;
                    case (opcode)
                        OP_LW:   cur <= S_MEMREAD;
                        OP_SW:   cur <= S_MEMWRITE;
                        default: cur <= S_ILLEGAL;
                    endcase
                end
                S_EXECUTE: begin
                    cnt <= '0;
                    cur <= S_ALUWB;
                end
                S_MEMWB, S_ALUWB, S_BRANCH: begin
                    cnt <= '0;
                    cur <= S_FETCH;
                end
                default: begin
                    cnt <= '0;
                    cur <= S_ILLEGAL;
                end
            endcase
        end
    end

    // All strobes are gated by reset so nothing reaches the datapath while it is low.
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        if (reset) begin
            case (cur)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = last;
                    pc_write  = last;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMREAD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    branch    = 1'b1;
                    pc_src    = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
        pc_en = pc_write | (branch & zero);
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: three instances (MEM_WAIT 0,1,2)
// checked cycle by cycle against a per-instruction state schedule.
module tb_multicycle_controller;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst [N];
    logic [5:0]  opc [N];
    logic        zz  [N];
    logic [3:0]  st  [N];
    logic [16:0] ctl [N];

    int checks = 0;
    int errors = 0;
    int pcw_cnt [N];
    int sched[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic       pc_en, pc_write, branch, pc_src, iord;
        logic       mem_read, mem_write, ir_write, reg_dst;
        logic       mem_to_reg, reg_write, alu_src_a, illegal;
        logic [1:0] alu_src_b, alu_op;

        multicycle_controller #(.MEM_WAIT(g)) dut (
            .clock(clk),
            .reset(rst[g]),
            .opcode(opc[g]),
            .zero(zz[g]),
            .state(st[g]),
            .pc_en(pc_en),
            .pc_write(pc_write),
            .branch(branch),
            .pc_src(pc_src),
            .iord(iord),
            .mem_read(mem_read),
            .mem_write(mem_write),
            .ir_write(ir_write),
            .reg_dst(reg_dst),
            .mem_to_reg(mem_to_reg),
            .reg_write(reg_write),
            .alu_src_a(alu_src_a),
            .alu_src_b(alu_src_b),
            .alu_op(alu_op),
            .illegal(illegal)
        );

        assign ctl[g] = {pc_en, pc_write, branch, pc_src, iord,
                         mem_read, mem_write, ir_write, reg_dst,
                         mem_to_reg, reg_write, alu_src_a,
                         alu_src_b, alu_op, illegal};
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected strobes for one cycle, from the per-state output table.
    function automatic logic [16:0] exp_ctrl(int s, bit last, bit z);
        logic pcw, br, psrc, iord, mr, mw, irw, rd, m2r, rw, asa, ill;
        logic [1:0] asb, aop;
        {pcw, br, psrc, iord, mr, mw, irw, rd, m2r, rw, asa, ill} = '0;
        asb = 2'b00;
        aop = 2'b00;
        case (s)
            0: begin mr = 1; asb = 2'b01; pcw = last; irw = last; end
            1: asb = 2'b11;
            2: begin asa = 1; asb = 2'b10; end
            3: begin mr = 1; iord = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mw = 1; iord = 1; end
            6: begin asa = 1; aop = 2'b10; end
            7: begin rw = 1; rd = 1; end
            8: begin asa = 1; aop = 2'b01; br = 1; psrc = 1; end
            default: ill = 1;
        endcase
        return {pcw | (br & z), pcw, br, psrc, iord, mr, mw, irw, rd,
                m2r, rw, asa, asb, aop, ill};
    endfunction

    function automatic int lat_of(logic [5:0] op, int w);
        case (op)
            6'd35:   return 5 + 2 * w;
            6'd43:   return 4 + 2 * w;
            6'd0:    return 4 + w;
            default: return 3 + w;
        endcase
    endfunction

    // Entry = state code, +256 marks the final fetch cycle.
    task automatic build_sched(input int w, input logic [5:0] op);
        sched.delete();
        for (int i = 0; i <= w; i++) sched.push_back(i == w ? 256 : 0);
        sched.push_back(1);
        case (op)
            6'd35: begin
                sched.push_back(2);
                for (int i = 0; i <= w; i++) sched.push_back(3);
                sched.push_back(4);
            end
            6'd43: begin
                sched.push_back(2);
                for (int i = 0; i <= w; i++) sched.push_back(5);
            end
            6'd0: begin
                sched.push_back(6);
                sched.push_back(7);
            end
            6'd4: sched.push_back(8);
            default: for (int i = 0; i < 22; i++) sched.push_back(9);
        endcase
    endtask

    task automatic check_cycle(input int k, input int c, input int e,
                               input logic z);
        check($sformatf("state_i%0d_c%0d", k, c), st[k], e & 255);
        check($sformatf("ctrl_i%0d_c%0d_s%0d", k, c, e & 255), ctl[k],
              exp_ctrl(e & 255, e >= 256, z));
    endtask

    // Called at posedge+1 of the first fetch cycle; returns the same way.
    task automatic run_instr(input int k, input logic [5:0] op,
                             input logic z);
        int  lat = 0;
        bit  nz = 0;
        bit  done = 0;
        opc[k] = op;
        zz[k] = z;
        build_sched(k, op);
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (c < sched.size()) check_cycle(k, c, sched[c], z);
            else check($sformatf("overrun_i%0d", k), c, sched.size());
            if (ctl[k][15]) pcw_cnt[k]++;
            if (st[k] != 4'd0) nz = 1;
            lat++;
            @(posedge clk);
            #1;
            if (nz && st[k] == 4'd0) done = 1;
        end
        check($sformatf("latency_i%0d_op%0d", k, op), lat, lat_of(op, k));
    endtask

    task automatic run_illegal(input int k, input logic [5:0] op);
        opc[k] = op;
        zz[k] = 1'($urandom_range(1));
        build_sched(k, op);
        foreach (sched[c]) begin
            @(negedge clk);
            check_cycle(k, c, sched[c], zz[k]);
            @(posedge clk);
            #1;
        end
        rst[k] = 1'b0;
        @(negedge clk);
        check($sformatf("ill_rst_state_i%0d", k), st[k], 9);
        check($sformatf("ill_rst_ctrl_i%0d", k), ctl[k], 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check($sformatf("ill_after_rst_i%0d", k), st[k], 0);
        @(posedge clk);
        #1;
        rst[k] = 1'b1;
    endtask

    task automatic reset_mid(input int k);
        opc[k] = 6'd35;
        zz[k] = 1'b1;
        build_sched(k, 6'd35);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst[k] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_state_i%0d_%0d", k, i), st[k],
                  i == 0 ? sched[3] : 0);
            check($sformatf("rst_ctrl_i%0d_%0d", k, i), ctl[k], 0);
            @(posedge clk);
            #1;
        end
        rst[k] = 1'b1;
    endtask

    initial begin
        logic [5:0] op;
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b0;
            opc[k] = 6'd0;
            zz[k] = 1'b0;
            pcw_cnt[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check($sformatf("por_state_i%0d", k), st[k], 0);
            check($sformatf("por_ctrl_i%0d", k), ctl[k], 0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1;
            run_instr(k, 6'd35, 1'b0);
            run_instr(k, 6'd43, 1'b1);
            run_instr(k, 6'd0, 1'b1);
            run_instr(k, 6'd4, 1'b1);
            run_instr(k, 6'd4, 1'b0);
            pcw_cnt[k] = 0;
            run_instr(k, 6'd35, 1'b0);
            run_instr(k, 6'd43, 1'b0);
            run_instr(k, 6'd0, 1'b0);
            run_instr(k, 6'd4, 1'b1);
            check($sformatf("pcw_count_i%0d", k), pcw_cnt[k], 4);
            reset_mid(k);
            run_instr(k, 6'd0, 1'b1);
            repeat (25) begin
                case ($urandom_range(3))
                    0: op = 6'd0;
                    1: op = 6'd4;
                    2: op = 6'd35;
                    default: op = 6'd43;
                endcase
                run_instr(k, op, 1'($urandom_range(1)));
            end
            run_illegal(k, 6'd2);
            run_instr(k, 6'd43, 1'b0);
            do op = 6'($urandom_range(63));
            while (op == 6'd0 || op == 6'd4 || op == 6'd35 || op == 6'd43);
            run_illegal(k, op);
            run_instr(k, 6'd35, 1'b1);
            rst[k] = 1'b0;
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
